// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one fixed-latency word memory between fetch and LSU.
// Word/halfword requests become aligned word accesses with big-endian byte enables.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0]       req_write_i,
    input  logic [1:0][1:0]  req_size_i,
    input  logic [1:0][31:0] req_addr_i,
    input  logic [1:0][31:0] req_wdata_i,
    output logic [1:0]       resp_valid_o,
    output logic [31:0]      resp_rdata_o,
    output logic             resp_err_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        half_lo_q, half_lo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept;
    logic        gnt;
    logic        sel_write;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;

    // Halfword select follows big-endian order: addr[1] = 0 picks the upper half.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic lo);
        logic [15:0] half;
        half = lo ? word[15:0] : word[31:16];
        case (size)
            2'd2:    extract = {{16{half[15]}}, half};
            2'd3:    extract = {16'h0000, half};
            default: extract = word;
        endcase
    endfunction

    always_comb begin
        gnt         = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
        accept      = (state_q == StIdle) && (|req_valid_i);
        req_ready_o = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        sel_write   = req_write_i[gnt];
        sel_size    = req_size_i[gnt];
        sel_addr    = req_addr_i[gnt];
        sel_wdata   = req_wdata_i[gnt];
        case (sel_size)
            2'd1:       sel_legal = (sel_addr[1:0] == 2'b00);
            2'd2, 2'd3: sel_legal = ~sel_addr[0];
            default:    sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        write_d      = write_q;
        size_d       = size_q;
        half_lo_d    = half_lo_q;
        cnt_d        = 4'd0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 2'b00;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    last_grant_d = gnt;
                    port_d       = gnt;
                    write_d      = sel_write;
                    size_d       = sel_size;
                    half_lo_d    = sel_addr[1];
                    if (sel_legal) begin
                        state_d     = StAccess;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_write;
                        mem_addr_d  = {sel_addr[31:2], 2'b00};
                        mem_be_d    = (sel_size == 2'd1) ? 4'b1111 :
                                      (sel_addr[1] ? 4'b0011 : 4'b1100);
                        mem_wdata_d = (sel_size == 2'd1) ? sel_wdata :
                                      {sel_wdata[15:0], sel_wdata[15:0]};
                    end else begin
                        // Illegal requests bypass memory and answer next cycle.
                        state_d      = StResp;
                        resp_valid_d = gnt ? 2'b10 : 2'b01;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(MEM_LATENCY)) begin
                    state_d      = StResp;
                    resp_valid_d = port_q ? 2'b10 : 2'b01;
                    resp_rdata_d = write_q ? 32'h0 : extract(mem_rdata_i, size_q, half_lo_q);
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            half_lo_q    <= 1'b0;
            cnt_q        <= 4'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 2'b00;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            write_q      <= write_d;
            size_q       <= size_d;
            half_lo_q    <= half_lo_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_be_o     = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory strobes and responses; a small memory array answers after MEM_LATENCY cycles.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned L = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_size;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [31:0]      resp_rdata;
    logic             resp_err;
    logic             mem_en;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int          free_cyc, exp_en_cyc, exp_resp_cyc, rd_cyc, acc_port, e_port;
    bit          m_last;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    bit          e_we, e_err;
    logic [31:0] ref_mem [16];
    logic [31:0] mem_arr [16];
    logic [3:0]  rd_idx;
    logic [31:0] last_rdata, last_mem_wdata, last_mem_addr;
    logic [3:0]  last_mem_be;
    logic        last_err;
    int          grants[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        free_cyc     = cyc;
        exp_en_cyc   = -1;
        exp_resp_cyc = -1;
        rd_cyc       = -1;
        acc_port     = -1;
        m_last       = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, {23'b0, resp_valid, resp_err, mem_en, mem_we, mem_be}, 32'h0);
        check_eq({tag, "_rdata"}, resp_rdata, 32'h0);
        check_eq({tag, "_addr"}, mem_addr, 32'h0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    // Called with this cycle's inputs already driven; returns at the next negedge.
    task automatic tick();
        logic [1:0]  exp_rdy;
        int          g;
        logic [31:0] a, w, word, half;
        logic [1:0]  sz;
        bit          wr, legal;
        g       = 0;
        exp_rdy = 2'b00;
        #1;
        acc_port = -1;
        if (cyc >= free_cyc && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = m_last ? 0 : 1;
            else g = req_valid[1] ? 1 : 0;
            exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        end
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 2'b00) begin
            acc_port = g;
            e_port   = g;
            m_last   = (g == 1);
            a  = req_addr[g];
            w  = req_wdata[g];
            sz = req_size[g];
            wr = req_write[g];
            legal = (sz == 2'd1 && a % 4 == 0) || (sz >= 2'd2 && a % 2 == 0);
            if (legal) begin
                exp_en_cyc   = cyc + 1;
                exp_resp_cyc = cyc + 2 + L;
                free_cyc     = cyc + 3 + L;
                e_addr  = a & 32'hFFFF_FFFC;
                e_we    = wr;
                e_err   = 1'b0;
                e_be    = (sz == 2'd1) ? 4'hF : (a[1] ? 4'h3 : 4'hC);
                e_wdata = (sz == 2'd1) ? w : ((w & 32'hFFFF) * 32'h0001_0001);
                word    = ref_mem[a[5:2]];
                if (wr) begin
                    e_rdata = 32'h0;
                    if (sz == 2'd1) ref_mem[a[5:2]] = w;
                    else if (a[1]) ref_mem[a[5:2]] = (word & 32'hFFFF_0000) | (w & 32'hFFFF);
                    else ref_mem[a[5:2]] = (word & 32'h0000_FFFF) | (w << 16);
                end else begin
                    half = a[1] ? (word & 32'hFFFF) : (word >> 16);
                    if (sz == 2'd1) e_rdata = word;
                    else if (sz == 2'd2 && half >= 32'h8000) e_rdata = half | 32'hFFFF_0000;
                    else e_rdata = half;
                end
            end else begin
                exp_resp_cyc = cyc + 1;
                free_cyc     = cyc + 2;
                e_err        = 1'b1;
                e_rdata      = 32'h0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("mem_en", 32'(mem_en), 32'(cyc == exp_en_cyc));
        if (cyc == exp_en_cyc) begin
            check_eq("mem_addr", mem_addr, e_addr);
            check_eq("mem_we", 32'(mem_we), 32'(e_we));
            check_eq("mem_be", 32'(mem_be), 32'(e_be));
            if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
        end
        check_eq("resp_valid", 32'(resp_valid),
                 (cyc == exp_resp_cyc) ? ((e_port == 1) ? 32'd2 : 32'd1) : 32'd0);
        if (cyc == exp_resp_cyc) begin
            check_eq("resp_rdata", resp_rdata, e_rdata);
            check_eq("resp_err", 32'(resp_err), 32'(e_err));
            last_rdata = resp_rdata;
            last_err   = resp_err;
        end
        if (mem_en) begin
            last_mem_wdata = mem_wdata;
            last_mem_be    = mem_be;
            last_mem_addr  = mem_addr;
            rd_idx         = mem_addr[5:2];
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) mem_arr[rd_idx][i*8 +: 8] = mem_wdata[i*8 +: 8];
            end else begin
                rd_cyc = cyc + L;
            end
        end
        mem_rdata = (cyc == rd_cyc) ? mem_arr[rd_idx] : $urandom;
    endtask

    task automatic set_req(input int p, input bit wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] w);
        req_write[p] = wr;
        req_size[p]  = sz;
        req_addr[p]  = a;
        req_wdata[p] = w;
    endtask

    task automatic issue(input int p, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] w);
        int n;
        n = 0;
        req_valid    = 2'b00;
        req_valid[p] = 1'b1;
        set_req(p, wr, sz, a, w);
        do begin
            tick();
            n++;
        end while (acc_port != p && n < 50);
        if (acc_port != p) check_eq("issue_accept", 32'(acc_port), 32'(p));
        req_valid = 2'b00;
        while (cyc < free_cyc) tick();
    endtask

    task automatic rand_req(input int p);
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        r  = $urandom % 8;
        sz = (r == 0) ? 2'd0 : 2'(1 + r % 3);
        a  = $urandom & 32'h3F;
        if ($urandom % 4 != 0) a = (sz == 2'd1) ? (a & 32'h3C) : (a & 32'h3E);
        set_req(p, 1'($urandom), sz, a, $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            mem_arr[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        mem_arr[4] = 32'hDEAD_BEEF;
        ref_mem[0] = 32'h8001_7FFF;
        mem_arr[0] = 32'h8001_7FFF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // Word load, port 1
        issue(1, 1'b0, 2'd1, 32'h10, 32'h0);
        check_eq("word_load", last_rdata, 32'hDEAD_BEEF);
        check_eq("word_load_be", 32'(last_mem_be), 32'hF);

        // Halfword loads from 0x8001_7FFF
        issue(0, 1'b0, 2'd2, 32'h02, 32'h0);
        check_eq("lh_lo", last_rdata, 32'h0000_7FFF);
        issue(0, 1'b0, 2'd2, 32'h00, 32'h0);
        check_eq("lh_hi", last_rdata, 32'hFFFF_8001);
        issue(0, 1'b0, 2'd3, 32'h00, 32'h0);
        check_eq("lhu_hi", last_rdata, 32'h0000_8001);

        // Halfword store
        issue(1, 1'b1, 2'd2, 32'h06, 32'h1234_ABCD);
        check_eq("sh_wdata", last_mem_wdata, 32'hABCD_ABCD);
        check_eq("sh_be", 32'(last_mem_be), 32'h3);
        check_eq("sh_addr", last_mem_addr, 32'h04);
        check_eq("sh_rdata", last_rdata, 32'h0);
        issue(0, 1'b0, 2'd1, 32'h04, 32'h0);

        // Misaligned word, then illegal size
        issue(0, 1'b0, 2'd1, 32'h03, 32'h0);
        check_eq("misaligned_err", 32'(last_err), 32'h1);
        issue(1, 1'b0, 2'd0, 32'h08, 32'h0);
        check_eq("size0_err", 32'(last_err), 32'h1);
        check_eq("size0_rdata", last_rdata, 32'h0);

        // Reset in the cycle after mem_en
        req_valid = 2'b01;
        set_req(0, 1'b0, 2'd1, 32'h20, 32'h0);
        n = 0;
        do begin
            tick();
            n++;
        end while (acc_port != 0 && n < 20);
        req_valid = 2'b00;
        while (cyc < exp_en_cyc && n < 40) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midreset_hold");
        rst_n = 1'b1;
        model_reset();

        // Both ports held valid: grants alternate starting with port 0
        rand_req(0);
        rand_req(1);
        req_valid = 2'b11;
        n = 0;
        while (grants.size() < 4 && n < 200) begin
            tick();
            if (acc_port >= 0) grants.push_back(acc_port);
            n++;
        end
        check_eq("tie_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size(); i++) check_eq("tie_grant", 32'(grants[i]), 32'(i % 2));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            req_valid = 2'($urandom);
            rand_req(0);
            rand_req(1);
            tick();
        end
        req_valid = 2'b00;
        while (cyc < free_cyc) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
